mem_arbiter: RTL and testbench

Round-robin arbiter that shares the single DDR memory port of mem_manager among NUM_REQ requesters (camera capture, image processing, host readout).
- Issues one 32-bit beat per cycle on behalf of the current owner.
- Honours mem_manager pause and controller_ready.
- Routes returning read data back to the issuing requester using a fixed-latency tag pipeline.
- Sits between the processing modules and mem_manager, in the clk domain.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/rr_pick.sv | 42 ++++
 rtl/mem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory-port arbiter: FSM encoding, default widths
// and the width helper used to size owner and beat-counter fields.
package mem_arb_pkg;

  localparam logic [0:0] ARB_IDLE  = 1'b0;
  localparam logic [0:0] ARB_BURST = 1'b1;

  localparam int ADDR_W_DEFAULT = 18;
  localparam int DATA_W_DEFAULT = 32;

  // Smallest r with 2**r >= value; used at elaboration time only
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set request strictly after the
// last owner, wrapping back to index 0.
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int OW      = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [OW-1:0]      last_i,
  output logic               found_o,
  output logic [OW-1:0]      next_o
);

  logic          hi_found;
  logic          lo_found;
  logic [OW-1:0] hi_idx;
  logic [OW-1:0] lo_idx;

  // Scan downward so the last hit in each half is its lowest index
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        if (i > int'(last_i)) begin
          hi_found = 1'b1;
          hi_idx   = OW'(i);
        end else begin
          lo_found = 1'b1;
          lo_idx   = OW'(i);
        end
      end
    end
  end

  assign found_o = hi_found | lo_found;
  assign next_o  = hi_found ? hi_idx : lo_idx;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the single mem_manager port among NUM_REQ
// requesters. One beat per cycle for the owner, bounded to MAX_BURST beats
// per grant, read data routed back through a fixed-latency tag pipeline.
// Optional build macro MEM_ARB_STATS_EN adds a saturating stall counter
// (stall_count) with a synchronous clear (stats_clear).
//
//   state     | meaning
//   ARB_IDLE  | no owner active; searching for the next requester
//   ARB_BURST | owner holds the port; beats issue when not paused
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int ADDR_W       = ADDR_W_DEFAULT,
  parameter int DATA_W       = DATA_W_DEFAULT,
  parameter int READ_LATENCY = 2,
  parameter int MAX_BURST    = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       controller_ready,
  input  logic                       mem_pause,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         req_wren,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_address,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data_write,
  output logic [NUM_REQ-1:0]         req_ack,
  output logic [NUM_REQ-1:0]         rd_valid,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       mem_req,
  output logic                       mem_wren,
  output logic [ADDR_W-1:0]          mem_address,
  output logic [DATA_W-1:0]          mem_data_write,
  input  logic [DATA_W-1:0]          mem_data_read,
  output logic [clog2(NUM_REQ)-1:0]  owner,
  output logic                       busy
`ifdef MEM_ARB_STATS_EN
  ,
  input  logic                       stats_clear,
  output logic [15:0]                stall_count
`endif
);

  localparam int OW = clog2(NUM_REQ);
  localparam int BW = clog2(MAX_BURST + 1);
  localparam int TW = READ_LATENCY * OW;

  logic [0:0]        state_q, state_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic              found;
  logic [OW-1:0]     next_owner;
  logic              issue;
  logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
  logic [DATA_W-1:0] wdata_arr [NUM_REQ];

  logic                    push_v;
  logic [READ_LATENCY-1:0] pipe_v_q, pipe_v_d;
  logic [TW-1:0]           pipe_id_q, pipe_id_d;
  logic [DATA_W-1:0]       rd_data_q;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_address[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = req_data_write[g*DATA_W +: DATA_W];
  end

  rr_pick #(.NUM_REQ(NUM_REQ), .OW(OW)) u_pick (
    .req_i   (req),
    .last_i  (owner_q),
    .found_o (found),
    .next_o  (next_owner)
  );

  assign busy  = (state_q == ARB_BURST);
  assign owner = owner_q;
  assign issue = busy & req[owner_q] & controller_ready & ~mem_pause;

  // Beat outputs follow the owner with zero latency and are zero when idle
  assign mem_req        = issue;
  assign mem_wren       = issue & req_wren[owner_q];
  assign mem_address    = issue ? addr_arr[owner_q]  : '0;
  assign mem_data_write = issue ? wdata_arr[owner_q] : '0;
  assign req_ack        = issue ? (NUM_REQ'(1) << owner_q) : '0;

  // Grant on the cycle after the search, release on owner drop or burst limit
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    beat_d  = beat_q;
    case (state_q)
      ARB_IDLE: begin
        if (controller_ready && found) begin
          owner_d = next_owner;
          beat_d  = '0;
          state_d = ARB_BURST;
        end
      end
      default: begin
        if (!req[owner_q]) begin
          state_d = ARB_IDLE;
        end else if (issue) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == BW'(MAX_BURST - 1)) state_d = ARB_IDLE;
        end
      end
    endcase
  end

  // FSM registers; owner resets to the last index so the first search starts at 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      owner_q <= OW'(NUM_REQ - 1);
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      beat_q  <= beat_d;
    end
  end

  // The last pipeline stage doubles as the output register for rd_valid/rd_data
  assign push_v    = issue & ~req_wren[owner_q];
  assign pipe_v_d  = READ_LATENCY'({pipe_v_q, push_v});
  assign pipe_id_d = TW'({pipe_id_q, owner_q});

  // Read tag pipeline shifts every cycle regardless of mem_pause
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_v_q  <= '0;
      pipe_id_q <= '0;
      rd_data_q <= '0;
    end else begin
      pipe_v_q  <= pipe_v_d;
      pipe_id_q <= pipe_id_d;
      rd_data_q <= pipe_v_d[READ_LATENCY-1] ? mem_data_read : '0;
    end
  end

  assign rd_valid = pipe_v_q[READ_LATENCY-1] ? (NUM_REQ'(1) << pipe_id_q[TW-1 -: OW]) : '0;
  assign rd_data  = rd_data_q;

`ifdef MEM_ARB_STATS_EN
  logic [15:0] stall_q;

  // Saturating count of cycles where the owner wants a beat but none issues
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if (stats_clear) begin
      stall_q <= '0;
    end else if (busy && req[owner_q] && !issue && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (default parameters).
module tb_mem_arbiter;

  localparam int NR = 4;
  localparam int AW = 18;
  localparam int DW = 32;
  localparam int MB = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             controller_ready = 1'b0;
  logic             mem_pause = 1'b0;
  logic [NR-1:0]    req = '0;
  logic [NR-1:0]    req_wren = '0;
  logic [NR*AW-1:0] req_address = '0;
  logic [NR*DW-1:0] req_data_write = '0;
  logic [NR-1:0]    req_ack;
  logic [NR-1:0]    rd_valid;
  logic [DW-1:0]    rd_data;
  logic             mem_req;
  logic             mem_wren;
  logic [AW-1:0]    mem_address;
  logic [DW-1:0]    mem_data_write;
  logic [DW-1:0]    mem_data_read = '0;
  logic [1:0]       owner;
  logic             busy;
`ifdef MEM_ARB_STATS_EN
  logic             stats_clear = 1'b0;
  logic [15:0]      stall_count;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .controller_ready (controller_ready),
    .mem_pause        (mem_pause),
    .req              (req),
    .req_wren         (req_wren),
    .req_address      (req_address),
    .req_data_write   (req_data_write),
    .req_ack          (req_ack),
    .rd_valid         (rd_valid),
    .rd_data          (rd_data),
    .mem_req          (mem_req),
    .mem_wren         (mem_wren),
    .mem_address      (mem_address),
    .mem_data_write   (mem_data_write),
    .mem_data_read    (mem_data_read),
    .owner            (owner),
    .busy             (busy)
`ifdef MEM_ARB_STATS_EN
    ,
    .stats_clear      (stats_clear),
    .stall_count      (stall_count)
`endif
  );

  // Reset for two edges, release just after a rising edge
  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    req = 4'b0001; req_wren = '0; req_address = '0; req_data_write = '0;
    req_address[0 +: AW] = 18'h00010;
    controller_ready = 1'b1; mem_pause = 1'b0; mem_data_read = '0;
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_assert++;
      if ({req_ack, rd_valid, mem_req, busy} !== 10'b0) begin
        n_fail++; $display("FAIL reset_outputs: got ack=%b rdv=%b mreq=%b busy=%b expected all 0", req_ack, rd_valid, mem_req, busy);
      end
    end
    n_assert++;
    if (owner !== 2'd3) begin n_fail++; $display("FAIL reset_owner: got %0d expected 3", owner); end
    n_assert++;
    if ({mem_address, mem_data_write, rd_data, mem_wren} !== '0) begin
      n_fail++; $display("FAIL reset_data: got addr=%h wd=%h rd=%h wren=%b expected 0", mem_address, mem_data_write, rd_data, mem_wren);
    end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    n_assert++;
    if ({req_ack, busy} !== 5'b0) begin n_fail++; $display("FAIL reset_bubble: got ack=%b busy=%b expected 0", req_ack, busy); end
    @(posedge clk); #1;
    @(negedge clk);
    n_assert++;
    if ({req_ack, mem_req, mem_wren, mem_address} !== {4'b0001, 1'b1, 1'b0, 18'h00010}) begin
      n_fail++; $display("FAIL reset_first_ack: got ack=%b mreq=%b wren=%b addr=%h expected 0001/1/0/00010", req_ack, mem_req, mem_wren, mem_address);
    end
    @(posedge clk); #1 req = '0; mem_data_read = 32'hCAFE0010;
    @(negedge clk);
    n_assert++;
    if (rd_valid !== 4'b0) begin n_fail++; $display("FAIL reset_rd_early: got %b expected 0000", rd_valid); end
    @(posedge clk); #1;
    @(negedge clk);
    n_assert++;
    if ({rd_valid, rd_data} !== {4'b0001, 32'hCAFE0010}) begin
      n_fail++; $display("FAIL reset_rd_return: got rdv=%b data=%h expected 0001 cafe0010", rd_valid, rd_data);
    end
    @(posedge clk); #1 mem_data_read = '0;
    @(negedge clk);
    n_assert++;
    if (rd_valid !== 4'b0) begin n_fail++; $display("FAIL reset_rd_single: got %b expected 0000", rd_valid); end
  endtask

  task automatic test_round_robin();
    logic [AW-1:0] exp_addr [NR];
    int            exp_own;
    req = 4'b1111; req_wren = 4'b1111; mem_pause = 1'b0; controller_ready = 1'b1;
    for (int i = 0; i < NR; i++) begin
      exp_addr[i] = AW'(18'h00100 * (i + 1));
      req_address[i*AW +: AW]    = exp_addr[i];
      req_data_write[i*DW +: DW] = 32'hA0A00000 + i;
    end
    do_reset();
    @(negedge clk);
    n_assert++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rr_first_bubble: got busy=%b expected 0", busy); end
    for (int g = 0; g < 5; g++) begin
      exp_own = g % NR;
      for (int k = 0; k < MB; k++) begin
        @(negedge clk);
        n_assert++;
        if ({req_ack, mem_wren, mem_address, mem_data_write} !==
            {(4'b0001 << exp_own), 1'b1, exp_addr[exp_own], 32'hA0A00000 + exp_own}) begin
          n_fail++;
          $display("FAIL rr_beat g%0d k%0d: got ack=%b wren=%b addr=%h wd=%h expected owner %0d", g, k, req_ack, mem_wren, mem_address, mem_data_write, exp_own);
        end
      end
      @(negedge clk);
      n_assert++;
      if ({req_ack, busy} !== 5'b0) begin n_fail++; $display("FAIL rr_bubble g%0d: got ack=%b busy=%b expected 0", g, req_ack, busy); end
    end
    req = '0;
  endtask

  task automatic test_pause();
    req = 4'b0100; req_wren = 4'b0100; mem_pause = 1'b0; controller_ready = 1'b1;
    req_address[2*AW +: AW] = 18'h2AAAA;
    req_data_write[2*DW +: DW] = 32'h55550002;
    do_reset();
    @(negedge clk);
    n_assert++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL pause_bubble: got busy=%b expected 0", busy); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_assert++;
      if ({req_ack, mem_wren, mem_address, mem_data_write} !== {4'b0100, 1'b1, 18'h2AAAA, 32'h55550002}) begin
        n_fail++; $display("FAIL pause_pre k%0d: got ack=%b wren=%b addr=%h wd=%h", k, req_ack, mem_wren, mem_address, mem_data_write);
      end
    end
    @(posedge clk); #1 mem_pause = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_assert++;
      if ({mem_req, req_ack, busy} !== 6'b000001) begin
        n_fail++; $display("FAIL pause_hold k%0d: got mreq=%b ack=%b busy=%b expected 0/0000/1", k, mem_req, req_ack, busy);
      end
    end
    @(posedge clk); #1 mem_pause = 1'b0;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      n_assert++;
      if ({req_ack, mem_req} !== 5'b01001) begin
        n_fail++; $display("FAIL pause_post k%0d: got ack=%b mreq=%b expected 0100/1", k, req_ack, mem_req);
      end
    end
    @(negedge clk);
    n_assert++;
    if ({req_ack, busy} !== 5'b0) begin n_fail++; $display("FAIL pause_end: got ack=%b busy=%b expected 0", req_ack, busy); end
`ifdef MEM_ARB_STATS_EN
    n_assert++;
    if (stall_count !== 16'd3) begin n_fail++; $display("FAIL pause_stall_count: got %0d expected 3", stall_count); end
`endif
    req = '0;
  endtask

  task automatic test_ready();
    req = 4'b0100; req_wren = '0; controller_ready = 1'b0; mem_pause = 1'b0;
    do_reset();
    repeat (4) begin
      @(negedge clk);
      n_assert++;
      if ({busy, mem_req, req_ack} !== 6'b0) begin
        n_fail++; $display("FAIL ready_low_idle: got busy=%b mreq=%b ack=%b expected 0", busy, mem_req, req_ack);
      end
    end
    @(posedge clk); #1 controller_ready = 1'b1;
    @(negedge clk);
    n_assert++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL ready_raise_idle: got busy=%b expected 0", busy); end
    @(negedge clk);
    n_assert++;
    if ({busy, owner, req_ack} !== {1'b1, 2'd2, 4'b0100}) begin
      n_fail++; $display("FAIL ready_grant: got busy=%b owner=%0d ack=%b expected 1/2/0100", busy, owner, req_ack);
    end
    @(posedge clk); #1 controller_ready = 1'b0;
    @(negedge clk);
    n_assert++;
    if ({busy, mem_req, req_ack} !== 6'b100000) begin
      n_fail++; $display("FAIL ready_drop_burst: got busy=%b mreq=%b ack=%b expected 1/0/0000", busy, mem_req, req_ack);
    end
    @(posedge clk); #1 req = '0; controller_ready = 1'b1;
  endtask

  task automatic test_read_order();
    req = 4'b0010; req_wren = '0; controller_ready = 1'b1; mem_pause = 1'b0; mem_data_read = '0;
    req_address[1*AW +: AW] = 18'h3FFFF;
    req_address[3*AW +: AW] = 18'h01234;
    do_reset();
    @(negedge clk);
    @(negedge clk);
    n_assert++;
    if ({req_ack, mem_wren, mem_address} !== {4'b0010, 1'b0, 18'h3FFFF}) begin
      n_fail++; $display("FAIL rd1_issue: got ack=%b wren=%b addr=%h expected 0010/0/3ffff", req_ack, mem_wren, mem_address);
    end
    @(posedge clk); #1 req = 4'b1000; mem_data_read = 32'h11110001;
    @(negedge clk);
    n_assert++;
    if ({req_ack, rd_valid} !== 8'b0) begin n_fail++; $display("FAIL rd1_gap: got ack=%b rdv=%b expected 0", req_ack, rd_valid); end
    @(posedge clk); #1;
    @(negedge clk);
    n_assert++;
    if ({rd_valid, rd_data, busy} !== {4'b0010, 32'h11110001, 1'b0}) begin
      n_fail++; $display("FAIL rd1_return: got rdv=%b data=%h busy=%b expected 0010/11110001/0", rd_valid, rd_data, busy);
    end
    @(posedge clk); #1 mem_data_read = '0;
    @(negedge clk);
    n_assert++;
    if ({req_ack, owner, rd_valid} !== {4'b1000, 2'd3, 4'b0000}) begin
      n_fail++; $display("FAIL rd3_issue: got ack=%b owner=%0d rdv=%b expected 1000/3/0000", req_ack, owner, rd_valid);
    end
    @(posedge clk); #1 req = '0; mem_data_read = 32'h33330003;
    @(negedge clk);
    n_assert++;
    if (rd_valid !== 4'b0) begin n_fail++; $display("FAIL rd3_early: got %b expected 0000", rd_valid); end
    @(posedge clk); #1;
    @(negedge clk);
    n_assert++;
    if ({rd_valid, rd_data} !== {4'b1000, 32'h33330003}) begin
      n_fail++; $display("FAIL rd3_return: got rdv=%b data=%h expected 1000/33330003", rd_valid, rd_data);
    end
    @(posedge clk); #1 mem_data_read = '0;
  endtask

  task automatic test_reset_inflight();
    req = 4'b0001; req_wren = '0; controller_ready = 1'b1; mem_pause = 1'b0; mem_data_read = '0;
    req_address[0 +: AW] = 18'h00055;
    do_reset();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_assert++;
      if (req_ack !== 4'b0001) begin n_fail++; $display("FAIL inflight_issue k%0d: got %b expected 0001", k, req_ack); end
    end
    @(posedge clk); #1 reset = 1'b1; req = '0; mem_data_read = 32'hDEADBEEF;
    @(negedge clk);
    n_assert++;
    if ({rd_valid, req_ack, mem_req, busy, mem_wren, mem_address, rd_data} !== '0 || owner !== 2'd3) begin
      n_fail++; $display("FAIL inflight_reset_outputs: got rdv=%b ack=%b mreq=%b busy=%b addr=%h rd=%h owner=%0d expected 0/owner 3",
                         rd_valid, req_ack, mem_req, busy, mem_address, rd_data, owner);
    end
    @(posedge clk); #1 reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_assert++;
      if (rd_valid !== 4'b0) begin n_fail++; $display("FAIL inflight_no_return: got %b expected 0000", rd_valid); end
    end
    mem_data_read = '0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_pause();
    test_ready();
    test_read_order();
    test_reset_inflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule
